// File: rtl/tpu_pkg.sv
// Shared types and constants for the TPU weight-path blocks.
// Holds the weight fetch FSM encoding and datapath sizing.
package tpu_pkg;

    localparam int WEIGHT_W       = 8;
    localparam int NUM_COLS       = 3;
    localparam int FIFO_DEPTH_DEF = 4;

    typedef enum logic [2:0] {
        IDLE,
        START,
        FETCH,
        DRAIN,
        DONE
    } wfc_state_t;

endpackage

// File: rtl/wfc_credit_counter.sv
// Saturating credit counter for the downstream weight FIFOs.
// Sticky error flag records a return of credit while already full.
module wfc_credit_counter
    import tpu_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic take_i,
    input  logic give_i,
    output logic avail_o,
    output logic err_o
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] MAX = CW'(DEPTH);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;

    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q | (give_i & (cnt_q == MAX));
        if (take_i && !give_i) begin
            cnt_d = cnt_q - 1'b1;
        end else if (give_i && !take_i && (cnt_q != MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= MAX;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign avail_o = (cnt_q != '0);
    assign err_o   = err_q;

endmodule

// File: rtl/weight_fetch_ctrl.sv
// Weight tile fetch controller: reads rows from weight memory into three column FIFOs.
// Define WFC_ROW_REVERSE_EN to fetch rows bottom-first.
module weight_fetch_ctrl
    import tpu_pkg::*;
#(
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int ADDR_W     = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [ADDR_W-1:0]            base_addr,
    input  logic [2:0]                   num_rows,
    output logic                         mem_rd_en,
    output logic [ADDR_W-1:0]            mem_addr,
    input  logic [WEIGHT_W*NUM_COLS-1:0] mem_rd_data,
    input  logic                         fifo_pop,
    output logic                         push_col0,
    output logic                         push_col1,
    output logic                         push_col2,
    output logic [WEIGHT_W-1:0]          data_col0,
    output logic [WEIGHT_W-1:0]          data_col1,
    output logic [WEIGHT_W-1:0]          data_col2,
    output logic                         weight_load_start,
    output logic                         busy,
    output logic                         done,
    output logic                         err_credit
);

    localparam int RW = $clog2(FIFO_DEPTH + 1);

    wfc_state_t        state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [RW-1:0]     rows_q, rows_d;
    logic [RW-1:0]     issued_q, issued_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [RW-1:0]     n_eff;
    logic [RW-1:0]     row_idx;
    logic              issue;
    logic              avail;
    logic              rd_en_q;
    logic              push_q;
    logic              wls_q;
    logic              busy_q;
    logic              done_q;

    assign n_eff = (int'(num_rows) > FIFO_DEPTH) ? RW'(FIFO_DEPTH)
                                                 : RW'(num_rows);

`ifdef WFC_ROW_REVERSE_EN
    assign row_idx = rows_q - RW'(1) - issued_q;
`else
    assign row_idx = issued_q;
`endif

    assign addr_d = base_q + ADDR_W'(row_idx);

    wfc_credit_counter #(
        .DEPTH (FIFO_DEPTH)
    ) u_credit (
        .clk     (clk),
        .rst     (rst),
        .take_i  (issue),
        .give_i  (fifo_pop),
        .avail_o (avail),
        .err_o   (err_credit)
    );

    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        rows_d   = rows_q;
        issued_d = issued_q;
        issue    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    base_d   = base_addr;
                    rows_d   = n_eff;
                    issued_d = '0;
                    state_d  = (n_eff == '0) ? DONE : START;
                end
            end
            // First read is issued from START so it lands in the first FETCH cycle.
            START: begin
                issue    = avail && (issued_q < rows_q);
                issued_d = issued_q + RW'(issue);
                state_d  = FETCH;
            end
            FETCH: begin
                issue    = avail && (issued_q < rows_q);
                issued_d = issued_q + RW'(issue);
                if (issued_d == rows_q) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!rd_en_q) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            base_q   <= '0;
            rows_q   <= '0;
            issued_q <= '0;
            addr_q   <= '0;
            rd_en_q  <= 1'b0;
            push_q   <= 1'b0;
            wls_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            rows_q   <= rows_d;
            issued_q <= issued_d;
            rd_en_q  <= issue;
            push_q   <= rd_en_q;
            wls_q    <= (state_d == START);
            busy_q   <= (state_d != IDLE);
            done_q   <= (state_d == DONE);
            if (issue) begin
                addr_q <= addr_d;
            end
        end
    end

    assign mem_rd_en         = rd_en_q;
    assign mem_addr          = addr_q;
    assign push_col0         = push_q;
    assign push_col1         = push_q;
    assign push_col2         = push_q;
    assign weight_load_start = wls_q;
    assign busy              = busy_q;
    assign done              = done_q;

    // Read data returns in the push cycle; the registered strobe gates it.
    assign data_col0 = push_q ? mem_rd_data[0*WEIGHT_W +: WEIGHT_W] : '0;
    assign data_col1 = push_q ? mem_rd_data[1*WEIGHT_W +: WEIGHT_W] : '0;
    assign data_col2 = push_q ? mem_rd_data[2*WEIGHT_W +: WEIGHT_W] : '0;

endmodule

// File: tb/tb_weight_fetch_ctrl.sv
// Randomized bench for weight_fetch_ctrl against a tile-level reference model.
// Honours WFC_ROW_REVERSE_EN for the expected address order.
module tb_weight_fetch_ctrl;

    localparam int D = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  base_addr;
    logic [2:0]  num_rows;
    logic        mem_rd_en;
    logic [7:0]  mem_addr;
    logic [23:0] mem_rd_data;
    logic        fifo_pop;
    logic        push_col0, push_col1, push_col2;
    logic [7:0]  data_col0, data_col1, data_col2;
    logic        weight_load_start, busy, done, err_credit;

    always #5 clk = ~clk;

    weight_fetch_ctrl #(
        .FIFO_DEPTH (D),
        .ADDR_W     (8)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .start             (start),
        .base_addr         (base_addr),
        .num_rows          (num_rows),
        .mem_rd_en         (mem_rd_en),
        .mem_addr          (mem_addr),
        .mem_rd_data       (mem_rd_data),
        .fifo_pop          (fifo_pop),
        .push_col0         (push_col0),
        .push_col1         (push_col1),
        .push_col2         (push_col2),
        .data_col0         (data_col0),
        .data_col1         (data_col1),
        .data_col2         (data_col2),
        .weight_load_start (weight_load_start),
        .busy              (busy),
        .done              (done),
        .err_credit        (err_credit)
    );

    logic [23:0] mem [256];
    always @(posedge clk) mem_rd_data <= mem_rd_en ? mem[mem_addr] : 24'h0;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vecs = 0;
    int errs = 0;
    int cr = D;
    bit err_m = 1'b0;

    logic [7:0]  obs_addr[$];
    int          obs_rd_cyc[$];
    logic [23:0] obs_push[$];
    int          obs_push_cyc[$];
    int wls_cnt, done_cnt, wls_cyc, done_cyc, col_bad;

    always @(negedge clk) begin
        if (mem_rd_en) begin
            obs_addr.push_back(mem_addr);
            obs_rd_cyc.push_back(cyc);
        end
        if (push_col0 | push_col1 | push_col2) begin
            if (!(push_col0 && push_col1 && push_col2)) col_bad++;
            obs_push.push_back({data_col2, data_col1, data_col0});
            obs_push_cyc.push_back(cyc);
        end
        if (weight_load_start) begin
            wls_cnt++;
            wls_cyc = cyc;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        vecs++;
        if (got != exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int clamp(input int nr);
        return (nr > D) ? D : nr;
    endfunction

    function automatic logic [7:0] exp_addr(input logic [7:0] b, input int n, input int i);
`ifdef WFC_ROW_REVERSE_EN
        return b + 8'(n - 1 - i);
`else
        return b + 8'(i);
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_obs();
        obs_addr.delete();
        obs_rd_cyc.delete();
        obs_push.delete();
        obs_push_cyc.delete();
        wls_cnt = 0;
        done_cnt = 0;
        wls_cyc = -1;
        done_cyc = -1;
        col_bad = 0;
    endtask

    task automatic do_pop();
        fifo_pop = 1'b1;
        if (cr == D) err_m = 1'b1;
        else cr++;
        tick();
        fifo_pop = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        start = 1'b0;
        fifo_pop = 1'b0;
        repeat (2) tick();
        chk("reset_ctrl", int'({mem_rd_en, push_col0, push_col1, push_col2,
                                weight_load_start, busy, done, err_credit}), 0);
        chk("reset_addr", int'(mem_addr), 0);
        chk("reset_data", int'({data_col2, data_col1, data_col0}), 0);
        rst = 1'b0;
        cr = D;
        err_m = 1'b0;
    endtask

    task automatic run_tile(input logic [7:0] b, input logic [2:0] nr);
        int n, cr0, got, t, lastp;
        logic [7:0] ea;
        n = clamp(int'(nr));
        cr0 = cr;
        clr_obs();
        base_addr = b;
        num_rows = nr;
        start = 1'b1;
        t = cyc;
        tick();
        base_addr = b + 8'h33;
        num_rows = nr ^ 3'd5;
        tick();
        start = 1'b0;
        repeat (8) tick();
        got = (n < cr0) ? n : cr0;
        chk("stall_reads", obs_addr.size(), got);
        while (got < n) begin
            do_pop();
            repeat (4) tick();
            got++;
            chk("credit_reads", obs_addr.size(), got);
        end
        for (int g = 0; g < 20 && done_cnt == 0; g++) tick();
        chk("done_seen", done_cnt, 1);
        tick();
        chk("idle_busy", int'(busy), 0);
        cr = cr - n;
        chk("push_count", obs_push.size(), n);
        for (int i = 0; i < n; i++) begin
            ea = exp_addr(b, n, i);
            chk("rd_addr", (i < obs_addr.size()) ? int'(obs_addr[i]) : -1, int'(ea));
            chk("push_data", (i < obs_push.size()) ? int'(obs_push[i]) : -1, int'(mem[ea]));
        end
        chk("wls_count", wls_cnt, int'(n > 0));
        chk("col_align", col_bad, 0);
        chk("err_flag", int'(err_credit), int'(err_m));
        if (n == 0) begin
            chk("zero_done_lat", done_cyc, t + 1);
        end else begin
            chk("wls_lat", wls_cyc, t + 1);
            lastp = (obs_push_cyc.size() > 0) ? obs_push_cyc[obs_push_cyc.size() - 1] : -100;
            chk("done_lat", done_cyc, lastp + 1);
            if (cr0 > 0) begin
                chk("rd_lat", (obs_rd_cyc.size() > 0) ? obs_rd_cyc[0] : -1, t + 2);
                chk("push_lat", (obs_push_cyc.size() > 0) ? obs_push_cyc[0] : -1, t + 3);
            end
            if (cr0 >= n) begin
                for (int i = 0; i < n; i++) begin
                    chk("rd_cyc", (i < obs_rd_cyc.size()) ? obs_rd_cyc[i] : -1, t + 2 + i);
                end
            end
        end
    endtask

    initial begin
        bit seen;
        int np;
        rst = 1'b1;
        start = 1'b0;
        fifo_pop = 1'b0;
        base_addr = 8'h00;
        num_rows = 3'd0;
        for (int i = 0; i < 256; i++) mem[i] = 24'($urandom);
        clr_obs();

        do_reset();

        mem[8'h10] = 24'h030201;
        mem[8'h11] = 24'h060504;
        mem[8'h12] = 24'h090807;
        run_tile(8'h10, 3'd3);

        repeat (3) do_pop();
        run_tile(8'h40, 3'd4);
        do_pop();
        run_tile(8'h50, 3'd4);

        repeat (4) do_pop();
        run_tile(8'hFE, 3'd7);

        run_tile(8'h20, 3'd0);

        do_pop();
        do_pop();
        clr_obs();
        base_addr = 8'h60;
        num_rows = 3'd4;
        start = 1'b1;
        tick();
        start = 1'b0;
        seen = 1'b0;
        for (int g = 0; g < 10 && !seen; g++) begin
            @(negedge clk);
            seen = mem_rd_en;
        end
        chk("mid_rd_seen", int'(seen), 1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_push", int'(push_col0 | push_col1 | push_col2), 0);
        chk("mid_busy", int'(busy), 0);
        chk("mid_rd", int'(mem_rd_en), 0);
        chk("mid_err", int'(err_credit), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cr = D;
        err_m = 1'b0;
        run_tile(8'h70, 3'd4);

        repeat (4) do_pop();
        chk("err_clear", int'(err_credit), 0);
        do_pop();
        tick();
        chk("err_set", int'(err_credit), 1);
        run_tile(8'h80, 3'd2);
        chk("err_sticky", int'(err_credit), 1);

        do_reset();
        for (int k = 0; k < 40; k++) begin
            np = $urandom_range(0, D - cr);
            if ($urandom_range(0, 7) == 0) np++;
            repeat (np) do_pop();
            run_tile(8'($urandom), 3'($urandom_range(0, 7)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
